// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: FSM state type and stream width default shared by the framer files.
package conv_stream_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/stream_skid2.sv
// stream_skid2: 2-entry FIFO-ordered valid/ready buffer; the writer is trusted never to overfill it.
module stream_skid2
    import conv_stream_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          pop;

    assign out_valid = occ_q != 2'd0;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign occ       = occ_q;

    always_comb begin
        mem_d = mem_q;
        if (in_valid) mem_d[wr_ptr_q] = in_data;
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q ^ in_valid;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, in_valid} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end
endmodule

// File: rtl/afifo_rd_framer.sv
// afifo_rd_framer: reads one IMG_W x IMG_H frame from a FIFO read port and emits it as a tagged valid/ready stream.
module afifo_rd_framer
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  m_sol,
    output logic                  m_eol
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int XW   = $clog2(IMG_W + 1);
    localparam int YW   = $clog2(IMG_H + 1);

    state_t          state_q, state_d;
    logic            infl_q, infl_d;
    logic            frame_done_q, frame_done_d;
    logic [IW-1:0]   issued_q, issued_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [1:0]      occ;
    logic            pop, last_x, last_y, eof_hs;

    stream_skid2 #(.DW(DATA_WIDTH)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (infl_q),
        .in_data  (fifo_rd_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .occ      (occ)
    );

    // Tags describe the head word, whose position is exactly the handshake counters.
    assign last_x     = x_q == XW'(IMG_W - 1);
    assign last_y     = y_q == YW'(IMG_H - 1);
    assign m_sol      = m_valid && x_q == '0;
    assign m_eol      = m_valid && last_x;
    assign m_sof      = m_sol && y_q == '0;
    assign m_eof      = m_eol && last_y;
    assign busy       = state_q == RUN;
    assign frame_done = frame_done_q;

    always_comb begin
        pop    = m_valid && m_ready;
        eof_hs = pop && last_x && last_y;
        // Reserve a slot for the word already in flight so the buffer can never overflow.
        fifo_rd_en = state_q == RUN && !fifo_rd_empty && issued_q < IW'(NPIX) &&
                     ({1'b0, occ} + {2'b0, infl_q} - {2'b0, pop}) <= 3'd1;
        state_d      = (state_q == IDLE) ? (start ? RUN : IDLE) : (eof_hs ? IDLE : RUN);
        infl_d       = fifo_rd_en;
        frame_done_d = eof_hs;
        issued_d     = eof_hs ? '0 : issued_q + IW'(fifo_rd_en);
        x_d          = (eof_hs || (pop && last_x)) ? '0 : x_q + XW'(pop);
        y_d          = eof_hs ? '0 : (pop && last_x) ? y_q + YW'(1) : y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            infl_q       <= 1'b0;
            frame_done_q <= 1'b0;
            issued_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            infl_q       <= infl_d;
            frame_done_q <= frame_done_d;
            issued_q     <= issued_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end
endmodule
